// File: rtl/uart_tx_if.sv
// Byte-wide producer-to-transmitter handshake for the UART transmit path.
// valid/ready: a byte moves on any rising edge where tx_valid and tx_ready are both 1;
// the producer holds tx_valid and tx_data stable until that edge, and tx_valid never waits on tx_ready.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a single byte holding register.
// RsTx comes straight from a flop; the falling start-bit edge follows the accept edge by one cycle.
module uart_tx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic        clk,
  input  logic        reset,
  uart_tx_if.slave    tx,
  output logic        tx_busy,
  output logic        RsTx,
  output logic [1:0]  dbg_state
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          bit_done;

  assign bit_done    = (baud_cnt == LAST_CNT);
  // Ready is gated by reset so a producer can never see a handshake during reset.
  assign tx.tx_ready = reset && (state == IDLE);
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      RsTx     <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          RsTx    <= 1'b1;
          tx_busy <= 1'b0;
          if (tx.tx_valid) begin
            shift_q  <= tx.tx_data;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_busy  <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          RsTx <= 1'b0;
          if (bit_done) begin
            baud_cnt <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          RsTx <= shift_q[0];
          if (bit_done) begin
            baud_cnt <= '0;
            shift_q  <= shift_q >> 1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          // The line stays high into IDLE, which stretches the stop bit by one cycle.
          RsTx <= 1'b1;
          if (bit_done) begin
            baud_cnt <= '0;
            tx_busy  <= 1'b0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at 10 clocks per bit: a frame-timeline model plus a line decoder
// and scoreboard, directed scenarios, then randomized traffic.
module tb_uart_tx;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_busy;
  logic       RsTx;
  logic [1:0] dbg_state;

  uart_tx_if u_if();

  uart_tx #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100)) dut (
    .clk       (clk),
    .reset     (reset),
    .tx        (u_if.slave),
    .tx_busy   (tx_busy),
    .RsTx      (RsTx),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] exp_q[$];
  int         m_last = -100000;   // edge index of the last accept
  logic [9:0] m_frame = '1;       // line bits of that frame, start bit at index 0
  int         busy_cnt  = 0;
  int         ready_cnt = 0;
  int         rx_frames = 0;
  int         rx_cnt    = -1;
  logic [7:0] rx_byte   = '0;
  logic       prev_rstx = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- model + per-cycle compare + line decoder ----------------
  always @(posedge clk) begin
    int d;
    int d_prev;
    logic e_busy;
    logic e_rstx;
    logic e_ready;
    cyc++;
    d_prev = cyc - 1 - m_last;
    if (!reset) begin
      m_last = -100000;
    end else if (u_if.tx_valid === 1'b1 && !(d_prev >= 0 && d_prev < 10*CPB)) begin
      m_last  = cyc;
      m_frame = {1'b1, u_if.tx_data, 1'b0};
      exp_q.push_back(u_if.tx_data);
    end
    #1;
    d       = cyc - m_last;
    e_busy  = (d >= 0 && d < 10*CPB);
    e_rstx  = (d >= 1 && d <= 10*CPB) ? m_frame[(d-1)/CPB] : 1'b1;
    e_ready = reset && !e_busy;
    check("busy",  tx_busy,       e_busy);
    check("rstx",  RsTx,          e_rstx);
    check("ready", u_if.tx_ready, e_ready);
    if (tx_busy === 1'b1) busy_cnt++;
    if (u_if.tx_ready === 1'b1) ready_cnt++;

    if (!reset) begin
      rx_cnt = -1;
      exp_q.delete();
    end else if (rx_cnt < 0) begin
      if (prev_rstx === 1'b1 && RsTx === 1'b0) rx_cnt = 0;
    end else begin
      rx_cnt++;
      if (rx_cnt >= 15 && rx_cnt <= 85 && (rx_cnt % 10) == 5)
        rx_byte[(rx_cnt-15)/10] = RsTx;
      if (rx_cnt == 95) begin
        check("rx_stop_bit", RsTx, 1'b1);
        check("rx_expected_pending", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("rx_byte", rx_byte, exp_q.pop_front());
        rx_frames++;
        rx_cnt = -1;
      end
    end
    prev_rstx = RsTx;
  end

  // ---------------- driver tasks ----------------
  // Returns 2 time units after the accept edge, with tx_data/tx_valid set to after/hold.
  task automatic send_byte(input logic [7:0] b, input logic [7:0] after, input bit hold);
    int n;
    n = 0;
    u_if.tx_data  = b;
    u_if.tx_valid = 1'b1;
    while (u_if.tx_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      check("accept_timeout", 32'd0, 32'd1);
      u_if.tx_valid = 1'b0;
      return;
    end
    @(posedge clk); #2;
    u_if.tx_data  = after;
    u_if.tx_valid = hold;
  endtask

  // Called right after send_byte; samples mid-bit and ends one cycle past the frame.
  task automatic sample_frame(output logic [9:0] bits);
    check("line_idle_on_accept", RsTx, 1'b1);
    @(posedge clk); #2;
    check("start_latency", RsTx, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    bits[0] = RsTx;
    for (int i = 1; i < 10; i++) begin
      repeat (10) @(posedge clk);
      #2;
      bits[i] = RsTx;
    end
    repeat (6) @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] bits;
    int a1;
    int a2;
    int frames0;

    u_if.tx_valid = 1'b0;
    u_if.tx_data  = 8'h00;
    reset         = 1'b0;

    // 1: reset held with the producer toggling
    repeat (5) begin
      @(negedge clk);
      u_if.tx_valid = 1'($urandom_range(0, 1));
      u_if.tx_data  = 8'($urandom);
      check("reset_rstx",  RsTx,          1'b1);
      check("reset_busy",  tx_busy,       1'b0);
      check("reset_ready", u_if.tx_ready, 1'b0);
    end
    @(negedge clk);
    u_if.tx_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("ready_after_release", u_if.tx_ready, 1'b1);
    @(posedge clk); #2;
    check("ready_first_cycle", u_if.tx_ready, 1'b1);

    // 2: 0x55
    busy_cnt = 0;
    send_byte(8'h55, 8'h55, 1'b0);
    sample_frame(bits);
    check("frame_55", bits, 10'b1010101010);
    check("busy_cycles_55", busy_cnt, 100);

    // 3: data changed right after accept
    send_byte(8'hA3, 8'hFF, 1'b0);
    sample_frame(bits);
    check("frame_a3", bits, 10'b1101000110);

    // 4: back-to-back with tx_valid held
    send_byte(8'h01, 8'h80, 1'b1);
    a1 = m_last;
    ready_cnt = 0;
    send_byte(8'h80, 8'h00, 1'b0);
    a2 = m_last;
    check("b2b_spacing", a2 - a1, 101);
    check("b2b_ready_cycles", ready_cnt, 1);
    repeat (110) @(posedge clk);
    #2;

    // 5: valid pulse mid-frame is ignored
    frames0 = rx_frames;
    send_byte(8'h5A, 8'h5A, 1'b0);
    a1 = m_last;
    repeat (30) @(posedge clk);
    #2;
    u_if.tx_valid = 1'b1;
    u_if.tx_data  = 8'h00;
    check("pulse_ready_low", u_if.tx_ready, 1'b0);
    @(posedge clk); #2;
    u_if.tx_valid = 1'b0;
    repeat (120) @(posedge clk);
    #2;
    check("pulse_no_accept", m_last, a1);
    check("pulse_one_frame", rx_frames - frames0, 1);
    check("pulse_queue_empty", exp_q.size(), 0);

    // 6: reset during data bit 3, then a clean frame
    send_byte(8'h0F, 8'h0F, 1'b0);
    repeat (45) @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk); #2;
    check("midreset_rstx",  RsTx,          1'b1);
    check("midreset_busy",  tx_busy,       1'b0);
    check("midreset_ready", u_if.tx_ready, 1'b0);
    @(posedge clk); #2;
    reset = 1'b1;
    frames0 = rx_frames;
    send_byte(8'h3C, 8'h3C, 1'b0);
    sample_frame(bits);
    check("frame_3c", bits, 10'b1001111000);
    check("frame_3c_decoded", rx_frames - frames0, 1);

    // randomized traffic with noise pulses while a frame is in flight
    for (int k = 0; k < 20; k++) begin
      int gap;
      send_byte(8'($urandom), 8'($urandom), 1'b0);
      gap = $urandom_range(0, 130);
      for (int g = 0; g < gap; g++) begin
        int d;
        @(negedge clk);
        d = cyc - m_last;
        if (d >= 0 && d < 90 && $urandom_range(0, 7) == 0) begin
          u_if.tx_valid = 1'b1;
          u_if.tx_data  = 8'($urandom);
        end else begin
          u_if.tx_valid = 1'b0;
        end
      end
      @(negedge clk);
      u_if.tx_valid = 1'b0;
    end
    repeat (120) @(posedge clk);
    #2;
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
